// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
//   state_t     : FSM encoding (IDLE, SHIFT)
//   next_shreg  : one-step shift toward the output end, zero fill
package piso_pkg;

  // Widest word the shift helper handles. Callers zero-extend into this
  // width and truncate the result back to their own WIDTH.
  localparam int MAX_W = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Left shift moves bit WIDTH-2 into the MSB-first output slot.
  // Right shift moves bit 1 into the LSB-first output slot. Because the
  // caller zero-extends, the upper padding bits are zero, so truncating
  // the result gives a correct zero fill in both directions.
  function automatic logic [MAX_W-1:0] next_shreg(input logic [MAX_W-1:0] s,
                                                  input logic             msb_first);
    return msb_first ? (s << 1) : (s >> 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with a zero flag. It tracks the remaining bit
// periods of the word currently being sent.
//   clk, rst : clock and synchronous active-high reset
//   load     : load load_val (takes priority over dec)
//   load_val : value loaded on load
//   dec      : decrement by one; ignored at zero, so the count never wraps
//   cnt      : current count
//   zero     : cnt == 0
module piso_bit_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (load)          cnt <= load_val;
    else if (dec && !zero)  cnt <= cnt - CW'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parameterised parallel-in/serial-out shifter with a valid/ready load
// handshake, shift-enable pacing and busy/last status. Words can be sent
// back to back without a gap.
//   clk, rst   : clock and synchronous active-high reset
//   load_valid : producer offers pin
//   load_ready : a word can be accepted this cycle (combinational)
//   pin        : parallel word, sampled only on an accepted load
//   shift_en   : advance one bit this cycle; 0 holds the current bit
//   sout       : serial data (registered); IDLE_LEVEL when no word is active
//   sout_valid : sout carries a data bit
//   busy       : word in progress
//   last       : sout carries the final bit of the current word
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pin,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);
  // Bit position that drives sout.
  localparam int OB = MSB_FIRST ? WIDTH - 1 : 0;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             accept;
  logic             dec;

  // Ready when idle, or at the closing edge of the last bit so the next
  // word follows without an idle cycle.
  assign load_ready = (state == IDLE) || (state == SHIFT && cnt_zero && shift_en);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    dec     = 1'b0;
    if (accept) begin
      shreg_n = pin;
      state_n = SHIFT;
    end else if (state == SHIFT && shift_en) begin
      if (!cnt_zero) begin
        shreg_n = WIDTH'(next_shreg(MAX_W'(shreg), MSB_FIRST));
        dec     = 1'b1;
      end else begin
        state_n = IDLE;
      end
    end
  end

  piso_bit_counter #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (CW'(WIDTH - 1)),
    .dec      (dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Outputs are registered from the next-state values so they line up
  // with state/shreg and change only on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      sout       <= IDLE_LEVEL;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      sout       <= (state_n == SHIFT) ? shreg_n[OB] : IDLE_LEVEL;
      sout_valid <= (state_n == SHIFT);
      busy       <= (state_n == SHIFT);
    end
  end

  assign last = busy && cnt_zero;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, se;
  logic       a_lv, a_lr, a_so, a_sv, a_busy, a_last;
  logic [7:0] a_pin;
  logic       b_lv, b_lr, b_so, b_sv, b_busy, b_last;
  logic [7:0] b_pin;
  logic       c_lv, c_lr, c_so, c_sv, c_busy, c_last;
  logic [3:0] c_pin;

  int total = 0;
  int bad   = 0;

  // 8-bit, MSB first, idle low
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
    .clk(clk), .rst(rst), .load_valid(a_lv), .load_ready(a_lr), .pin(a_pin),
    .shift_en(se), .sout(a_so), .sout_valid(a_sv), .busy(a_busy), .last(a_last));

  // 8-bit, LSB first, idle high
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_b (
    .clk(clk), .rst(rst), .load_valid(b_lv), .load_ready(b_lr), .pin(b_pin),
    .shift_en(se), .sout(b_so), .sout_valid(b_sv), .busy(b_busy), .last(b_last));

  // 4-bit, MSB first, idle low
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_c (
    .clk(clk), .rst(rst), .load_valid(c_lv), .load_ready(c_lr), .pin(c_pin),
    .shift_en(se), .sout(c_so), .sout_valid(c_sv), .busy(c_busy), .last(c_last));

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] bb;
    logic [10:0] st;
    logic [3:0]  cw;

    rst = 1'b1; se = 1'b1;
    a_lv = 1'b0; b_lv = 1'b0; c_lv = 1'b0;
    a_pin = '0; b_pin = '0; c_pin = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_a_sout", a_so, 1'b0);
    chk("rst_a_valid", a_sv, 1'b0);
    chk("rst_a_busy", a_busy, 1'b0);
    chk("rst_a_last", a_last, 1'b0);
    chk("rst_a_ready", a_lr, 1'b1);
    chk("rst_b_sout", b_so, 1'b1);
    chk("rst_c_sout", c_so, 1'b0);

    // single word C1, MSB first
    w = 8'hC1;
    a_pin = w; a_lv = 1'b1;
    tick();
    a_lv = 1'b0; a_pin = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("w1_sout[%0d]", i), a_so, w[7-i]);
      chk($sformatf("w1_valid[%0d]", i), a_sv, 1'b1);
      chk($sformatf("w1_busy[%0d]", i), a_busy, 1'b1);
      chk($sformatf("w1_last[%0d]", i), a_last, (i == 7));
      chk($sformatf("w1_ready[%0d]", i), a_lr, (i == 7));
      tick();
    end
    chk("w1_end_valid", a_sv, 1'b0);
    chk("w1_end_busy", a_busy, 1'b0);
    chk("w1_end_sout", a_so, 1'b0);
    chk("w1_end_ready", a_lr, 1'b1);

    // back to back C1 then 3C, load_valid held high
    bb = 16'hC13C;
    a_pin = 8'hC1; a_lv = 1'b1;
    tick();
    a_pin = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("bb_sout[%0d]", i), a_so, bb[15-i]);
      chk($sformatf("bb_valid[%0d]", i), a_sv, 1'b1);
      if (i == 7) chk("bb_ready_last", a_lr, 1'b1);
      if (i == 8) a_lv = 1'b0;
      tick();
    end
    chk("bb_end_valid", a_sv, 1'b0);

    // 3-cycle stall on bit 2; load_valid during the word must be ignored
    a_pin = 8'hC1; a_lv = 1'b1;
    tick();
    a_pin = 8'hFF;
    st = 11'b111_1100_0001;
    for (int c = 0; c < 11; c++) begin
      chk($sformatf("st_sout[%0d]", c), a_so, st[10-c]);
      chk($sformatf("st_valid[%0d]", c), a_sv, 1'b1);
      chk($sformatf("st_ready[%0d]", c), a_lr, (c == 10));
      se = !(c >= 1 && c <= 3);
      if (c == 10) a_lv = 1'b0;
      tick();
    end
    se = 1'b1;
    chk("st_end_valid", a_sv, 1'b0);
    chk("st_end_sout", a_so, 1'b0);

    // reset mid-word, then a fresh A5
    w = 8'hA5;
    a_pin = w; a_lv = 1'b1;
    tick();
    a_lv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pre_rst_sout[%0d]", i), a_so, w[7-i]);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_sout", a_so, 1'b0);
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_valid", a_sv, 1'b0);
    chk("mid_rst_ready", a_lr, 1'b1);
    chk("mid_rst_last", a_last, 1'b0);
    a_lv = 1'b1;
    tick();
    a_lv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a5_sout[%0d]", i), a_so, w[7-i]);
      chk($sformatf("a5_valid[%0d]", i), a_sv, 1'b1);
      tick();
    end
    chk("a5_end_valid", a_sv, 1'b0);

    // LSB first, idle high
    w = 8'hC1;
    chk("b_idle_sout", b_so, 1'b1);
    b_pin = w; b_lv = 1'b1;
    tick();
    b_lv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b_sout[%0d]", i), b_so, w[i]);
      chk($sformatf("b_valid[%0d]", i), b_sv, 1'b1);
      chk($sformatf("b_last[%0d]", i), b_last, (i == 7));
      tick();
    end
    chk("b_end_sout", b_so, 1'b1);
    chk("b_end_valid", b_sv, 1'b0);
    chk("b_end_busy", b_busy, 1'b0);

    // 4-bit word 1010
    cw = 4'b1010;
    c_pin = cw; c_lv = 1'b1;
    tick();
    c_lv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("c_sout[%0d]", i), c_so, cw[3-i]);
      chk($sformatf("c_last[%0d]", i), c_last, (i == 3));
      chk($sformatf("c_ready[%0d]", i), c_lr, (i == 3));
      tick();
    end
    chk("c_end_valid", c_sv, 1'b0);
    chk("c_end_sout", c_so, 1'b0);
    chk("c_end_busy", c_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
